// File: rtl/alu_fpga_pkg.sv
// rtl/alu_fpga_pkg.sv - shared types, glyph constants and hex decode for alu_fpga_seq
package alu_fpga_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/alu_fpga_seq_key_debounce.sv
// rtl/alu_fpga_seq_key_debounce.sv - key synchroniser, debouncer and press-pulse generator
module key_debounce #(
    parameter int DEB_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level_n,
    output logic press
);

    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // press_q rises in the same cycle the debounced level falls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
                level_q <= sync2_q;
                press_q <= ~sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign level_n = level_q;
    assign press   = press_q;

endmodule

// File: rtl/alu_fpga_seq.sv
// rtl/alu_fpga_seq.sv - key-driven operand/opcode capture, external ALU drive and hex display
module alu_fpga_seq
    import alu_fpga_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IN_W    = 16,
    parameter int SW_W    = 18,
    parameter int OP_W    = 4,
    parameter int NUM_HEX = 8,
    parameter int DEB_CYC = 500000
) (
    input  logic                 CLOCK_50,
    input  logic                 RST,
    input  logic [3:0]           KEY,
    input  logic [SW_W-1:0]      SW,
    output logic [7*NUM_HEX-1:0] HEX,
    output logic [7:0]           LEDR,
    output logic [OP_W-1:0]      aluop,
    output logic [DATA_W-1:0]    porta,
    output logic [DATA_W-1:0]    portb,
    input  logic [DATA_W-1:0]    porto,
    input  logic                 z_flag,
    input  logic                 v_flag,
    input  logic                 n_flag
);

    localparam int NUM_NIB = (DATA_W + 3) / 4;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   porta_q, porta_d;
    logic [DATA_W-1:0]   portb_q, portb_d;
    logic [OP_W-1:0]     aluop_q, aluop_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [2:0]          flags_q, flags_d;

    logic                adv, abt;
    logic                adv_level_n, abt_level_n;
    logic                unused_ok;
    logic signed [IN_W:0] sw_sext;
    logic [DATA_W-1:0]   live;
    logic [DATA_W-1:0]   disp;
    logic [4*NUM_HEX-1:0] disp_ext;
    logic [4:0]          state_oh;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_key_adv (
        .clk(CLOCK_50), .rst(RST), .raw_n(KEY[0]), .level_n(adv_level_n), .press(adv)
    );

    key_debounce #(.DEB_CYC(DEB_CYC)) u_key_abt (
        .clk(CLOCK_50), .rst(RST), .raw_n(KEY[1]), .level_n(abt_level_n), .press(abt)
    );

    assign unused_ok = ^{KEY[3:2], adv_level_n, abt_level_n, SW};

    assign sw_sext = $signed(SW[IN_W:0]);
    assign live    = DATA_W'(sw_sext);

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state_q  <= S_A;
            porta_q  <= '0;
            portb_q  <= '0;
            aluop_q  <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            porta_q  <= porta_d;
            portb_q  <= portb_d;
            aluop_q  <= aluop_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // Abort beats advance, except in S_EXEC which always runs to completion
    always_comb begin
        state_d  = state_q;
        porta_d  = porta_q;
        portb_d  = portb_q;
        aluop_d  = aluop_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (abt && state_q != S_EXEC) begin
            state_d = S_A;
            porta_d = '0;
            portb_d = '0;
            aluop_d = '0;
        end else begin
            case (state_q)
                S_A: if (adv) begin
                    porta_d = live;
                    state_d = S_B;
                end
                S_B: if (adv) begin
                    portb_d = live;
                    state_d = S_OP;
                end
                S_OP: if (adv) begin
                    aluop_d = SW[OP_W-1:0];
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    result_d = porto;
                    flags_d  = {n_flag, v_flag, z_flag};
                    state_d  = S_SHOW;
                end
                S_SHOW: if (adv) state_d = S_A;
                default: state_d = S_A;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            S_A, S_B: disp = live;
            S_OP:     disp = DATA_W'(SW[OP_W-1:0]);
            default:  disp = SW[SW_W-1] ? porta_q : result_q;
        endcase
        if (RST) disp = '0;
        disp_ext = (4*NUM_HEX)'(disp);
        HEX = '1;
        for (int d = 0; d < NUM_HEX; d++) begin
            HEX[7*d +: 7] = (d < NUM_NIB) ? hex_to_seg(disp_ext[4*d +: 4]) : SEG_BLANK;
        end
        state_oh = 5'b00001 << state_q;
        LEDR = {state_oh, flags_q};
    end

    assign aluop = aluop_q;
    assign porta = porta_q;
    assign portb = portb_q;

endmodule

// File: tb/tb_alu_fpga_seq.sv
// tb/tb_alu_fpga_seq.sv - scoreboard bench for alu_fpga_seq with randomized operands
module tb_alu_fpga_seq;

    localparam int DATA_W = 32;
    localparam int SW_W   = 18;
    localparam int OP_W   = 4;
    localparam int ST_A = 0, ST_B = 1, ST_OP = 2, ST_SHOW = 4;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        key;
    logic [SW_W-1:0]   sw;
    logic [55:0]       hex, hex16;
    logic [7:0]        ledr, ledr16;
    logic [OP_W-1:0]   aluop, aluop16;
    logic [31:0]       porta, portb, porto;
    logic [15:0]       porta16, portb16, porto16;
    logic              z_flag, v_flag, n_flag;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    int   m_st;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;

    always #5 clk = ~clk;

    alu_fpga_seq #(.DATA_W(32), .IN_W(16), .SW_W(18), .OP_W(4), .NUM_HEX(8), .DEB_CYC(4)) dut (
        .CLOCK_50(clk), .RST(rst), .KEY(key), .SW(sw), .HEX(hex), .LEDR(ledr),
        .aluop(aluop), .porta(porta), .portb(portb), .porto(porto),
        .z_flag(z_flag), .v_flag(v_flag), .n_flag(n_flag)
    );

    alu_fpga_seq #(.DATA_W(16), .IN_W(16), .SW_W(18), .OP_W(4), .NUM_HEX(8), .DEB_CYC(4)) dut16 (
        .CLOCK_50(clk), .RST(rst), .KEY(key), .SW(sw), .HEX(hex16), .LEDR(ledr16),
        .aluop(aluop16), .porta(porta16), .portb(portb16), .porto(porto16),
        .z_flag(1'b0), .v_flag(1'b0), .n_flag(1'b0)
    );

    assign porto16 = porta16 + portb16;

    // External ALU: ADD=2, SUB=3
    always_comb begin
        case (aluop)
            4'h2:    porto = porta + portb;
            4'h3:    porto = porta - portb;
            default: porto = porta & portb;
        endcase
        z_flag = (porto == 32'h0);
        n_flag = porto[31];
        case (aluop)
            4'h2:    v_flag = (porta[31] == portb[31]) && (porto[31] != porta[31]);
            4'h3:    v_flag = (porta[31] != portb[31]) && (porto[31] != porta[31]);
            default: v_flag = 1'b0;
        endcase
    end

    function automatic logic [55:0] glyphs(input logic [31:0] val, input int ndig);
        logic [55:0] g;
        for (int d = 0; d < 8; d++) g[7*d +: 7] = (d < ndig) ? SEG_TBL[val[4*d +: 4]] : 7'h7F;
        return g;
    endfunction

    function automatic logic [31:0] live_of(input logic [SW_W-1:0] s);
        return {{16{s[16]}}, s[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_st = ST_A; m_a = '0; m_b = '0; m_op = '0;
    endtask

    task automatic model_step(input bit adv, input bit abt);
        exp_t   e;
        longint sa, sb, ex;
        longint lim = 64'sd2147483647;
        if (abt) begin
            model_reset();
        end else if (adv) begin
            case (m_st)
                ST_A:  begin m_a = live_of(sw); m_st = ST_B; end
                ST_B:  begin m_b = live_of(sw); m_st = ST_OP; end
                ST_OP: begin
                    m_op = sw[3:0];
                    sa = longint'($signed(m_a));
                    sb = longint'($signed(m_b));
                    ex = (m_op == 4'h3) ? sa - sb : sa + sb;
                    e.res   = ex[31:0];
                    e.flags = {e.res[31], (ex > lim) || (ex < -lim - 1), e.res == 32'h0};
                    sb_q.push_back(e);
                    m_st = ST_SHOW;
                end
                default: m_st = ST_A;
            endcase
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_state"}, ledr[7:3], 5'b00001 << m_st);
        check({tag, "_porta"}, porta, m_a);
        check({tag, "_portb"}, portb, m_b);
        check({tag, "_aluop"}, aluop, m_op);
    endtask

    task automatic press(input logic [1:0] keys);
        model_step(keys[0], keys[1]);
        key[1:0] = ~keys;
        tick(8);
        key[1:0] = 2'b11;
        tick(10);
    endtask

    // Op press followed one cycle later by abort, so the abort pulse lands in S_EXEC
    task automatic press_op_then_abort();
        model_step(1'b1, 1'b0);
        key[0] = 1'b0;
        tick(1);
        key[1] = 1'b0;
        tick(7);
        key[0] = 1'b1;
        tick(1);
        key[1] = 1'b1;
        tick(10);
    endtask

    // Monitor: the cycle after S_EXEC must be S_SHOW with the expected result on display
    initial begin
        logic [4:0] prev_st;
        exp_t e;
        prev_st = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_st = '0;
            end else begin
                if (prev_st == 5'b01000) begin
                    check("exec_to_show", ledr[7:3], 5'b10000);
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("result_hex", hex, glyphs(e.res, 8));
                        check("flags", ledr[2:0], e.flags);
                    end
                end
                prev_st = ledr[7:3];
            end
        end
    end

    initial begin
        rst = 1'b1;
        key = 4'hF;
        sw  = '0;
        model_reset();
        tick(2);
        check("rst_ledr", ledr, 8'h08);
        check("rst_hex", hex, glyphs(32'h0, 8));
        check_model("rst");
        rst = 1'b0;
        tick(2);

        sw = 18'h00012;
        key[0] = 1'b0; tick(2); key[0] = 1'b1; tick(10);
        check_model("glitch");
        press(2'b01);
        check_model("one_adv");

        sw = 18'h00044;
        press(2'b11);
        check_model("adv_abt_same");

        sw = 18'h00005; press(2'b01);
        sw = 18'h00003; press(2'b01);
        check_model("seq_b");
        sw = 18'h00002; press(2'b01);
        check_model("seq_show");
        sw[17] = 1'b1;
        #1;
        check("disp_sel_a", hex, glyphs(m_a, 8));
        sw[17] = 1'b0;
        #1;
        check("disp_sel_res", hex, glyphs(32'h8, 8));
        press(2'b01);

        sw = 18'h10000; press(2'b01);
        check("sext_porta", porta, 32'hFFFF0000);
        sw = 18'h07FFF; press(2'b01);
        sw = 18'h00003; press_op_then_abort();
        check_model("exec_abort");
        check("sub_hex", hex, glyphs(32'hFFFE8001, 8));
        press(2'b01);

        sw = 18'h00005; press(2'b01);
        sw = 18'h00009; press(2'b01);
        check_model("pre_rst");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("midrst_ledr", ledr, 8'h08);
        check("midrst_hex", hex, glyphs(32'h0, 8));
        check_model("midrst");
        tick(1);
        rst = 1'b0;
        sw = 18'h0ABCD;
        #1;
        check("w16_hex", hex16, glyphs({16'h0, sw[15:0]}, 4));
        check("w16_upper_blank", hex16[55:28], {4{7'h7F}});

        for (int i = 0; i < 8; i++) begin
            sw = {1'b0, 1'($urandom_range(0, 1)), 16'($urandom)};
            press(2'b01);
            sw = {1'b0, 1'($urandom_range(0, 1)), 16'($urandom)};
            press(2'b01);
            if ($urandom_range(0, 3) == 0) begin
                press(2'b10);
                check_model("rnd_abort");
            end else begin
                sw = {14'h0, 4'($urandom_range(2, 3))};
                press(2'b01);
                check_model("rnd_show");
                press(2'b01);
            end
        end

        tick(4);
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_fpga_seq.md
Name: alu_fpga_seq

Overview:
- Parametrised, sequential successor to the board-level ALU wrapper.
- Operands and opcode are captured in registers through a key-driven state machine, with synchronised and debounced pushbuttons.
- Drives an external ALU (instantiated alongside, connected through the alu_if signals), registers the result and flags, and multiplexes live operand or result onto NUM_HEX seven-segment digits.
- Sits at the FPGA top level between the board I/O and the ALU.

Parameters:
- DATA_W, 32, ALU datapath width; must satisfy DATA_W <= 4*NUM_HEX.
- IN_W, 16, switch bits used as operand magnitude (SW[IN_W-1:0]); SW[IN_W] is the sign-fill bit.
- SW_W, 18, switch bus width; must be >= IN_W+2.
- OP_W, 4, ALU opcode width; opcode taken from SW[OP_W-1:0].
- NUM_HEX, 8, number of seven-segment digits.
- DEB_CYC, 500000, consecutive stable cycles required to accept a key level change.

Ports:
- CLOCK_50, in, 1, sole clock; all state is posedge.
- RST, in, 1, asynchronous, active-high reset.
- KEY, in, 4, board pushbuttons, active-low. KEY[0] = advance/capture, KEY[1] = abort, KEY[3:2] unused.
- SW, in, SW_W, switches. SW[SW_W-1] = display select in SHOW.
- HEX, out, 7*NUM_HEX, digit d occupies bits [7d+6:7d]; segments active-low.
- LEDR, out, 8, [2:0] = {n,v,z} registered flags; [7:3] = one-hot state.
- aluop, out, OP_W, registered opcode to the ALU.
- porta, out, DATA_W, registered operand A.
- portb, out, DATA_W, registered operand B.
- porto, in, DATA_W, ALU result (combinational from porta/portb/aluop).
- z_flag, v_flag, n_flag, in, 1 each, ALU flags.

Behaviour:
- Reset (async, RST=1):
  - state=S_A; porta, portb, aluop, result_q = 0; flags_q = 0.
  - Key synchronisers and debounced levels are forced to released (1); debounce counters = 0.
  - HEX shows all '0' glyphs (7'b1000000) on digits covering DATA_W, blank (7'h7F) above.
- Reset mid-operation discards all captured data; no partial state survives.
- Key conditioning, per key:
  - 2-flop synchroniser.
  - Counter increments while the synced level differs from the debounced level, and clears on any match.
  - At count = DEB_CYC-1 the debounced level takes the synced value.
  - A press pulse lasts exactly 1 cycle, on the debounced 1->0 transition. Release produces no event.
- Live operand: live = {{(DATA_W-IN_W){SW[IN_W]}}, SW[IN_W-1:0]}.
- FSM transitions (adv = KEY[0] pulse, abt = KEY[1] pulse):
  - S_A: adv -> porta <= live, go to S_B.
  - S_B: adv -> portb <= live, go to S_OP.
  - S_OP: adv -> aluop <= SW[OP_W-1:0], go to S_EXEC.
  - S_EXEC: unconditional, 1 cycle (ALU settle) -> result_q <= porto, flags_q <= {n,v,z}, go to S_SHOW.
  - S_SHOW: adv -> S_A. porta/portb/aluop/result_q are retained until overwritten.
- Abort:
  - abt in any state except S_EXEC -> S_A, clearing porta, portb and aluop to 0. result_q and flags are kept.
  - abt during S_EXEC is ignored; S_EXEC always completes.
- Simultaneous adv and abt in the same cycle: abt wins.
- Latency: the adv pulse in S_OP to valid result_q/LEDR flags is 2 clock edges.
- Display source:
  - S_A, S_B: live.
  - S_OP: zero-extended SW[OP_W-1:0].
  - S_EXEC, S_SHOW: result_q when SW[SW_W-1]=0; porta when SW[SW_W-1]=1.
  - Digits above ceil(DATA_W/4) are blank.
  - HEX is combinational from registered/switch state; no extra latency.
- LEDR[7:3] one-hot mapping: S_A=bit3, S_B=bit4, S_OP=bit5, S_EXEC=bit6, S_SHOW=bit7.

Decomposition:
- Package alu_fpga_pkg: state enum state_t {S_A, S_B, S_OP, S_EXEC, S_SHOW}, glyph constants SEG_BLANK=7'h7F, and a 16-entry hex-to-segment constant table.
- Sub-module key_debounce (parameter DEB_CYC): input raw_n, outputs level_n and press. Instantiated 2x (KEY[0], KEY[1]); it holds the synchroniser and counter.
- The hex decode is a package function, not a module.

Test Plan (bench uses DEB_CYC=4; the ALU model implements ADD=4'h2, SUB=4'h3):
- Assert RST mid-S_OP with porta=5 -> state=S_A, porta=portb=aluop=0, LEDR=8'h08, HEX0..7 show '0'.
- KEY[0] glitch low for 2 cycles -> no state change. Held low 8 cycles then released -> exactly one advance (S_A->S_B).
- Full sequence:
  - SW=16'h0005 capture A; SW=16'h0003 capture B; SW[3:0]=2 capture op.
  - Required: result_q=32'h8 exactly 2 edges after the op press; LEDR[2:0]=0; state S_SHOW.
- Sign extension and overflow flag:
  - A = SW[16]=1, SW[15:0]=16'h0000 -> porta=32'hFFFF0000; B=32'h7FFF with SUB.
  - Required: result 32'hFFFE8001, n=1, v=0, HEX7..0 show "FFFE8001".
- Abort: press KEY[0] and KEY[1] in the same cycle in S_B -> S_A with porta=0. An abort pulse in S_EXEC is ignored, and S_SHOW is reached with the correct result.
- Display select in S_SHOW: toggle SW[17] 0->1 -> HEX switches from result_q to porta in the same cycle. With a DATA_W=16, NUM_HEX=8 build, HEX7..HEX4 = 7'h7F.
